mdu_sequencer: RTL and testbench

// Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/mdu_sequencer.sv | 147 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one result bit per cycle, with single-cycle shortcuts for divide-by-zero and signed overflow.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] mb_q, mb_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic             negq_q, negq_d, negr_q, negr_d, spec_q, spec_d, done_q, done_d;

    // Operand decode at launch
    logic             is_div, sgn_a, sgn_b, sa, sb, div_zero, div_ovf;
    logic [WIDTH-1:0] mag_a, mag_b, spec_val;

    assign is_div   = Funct3[2];
    assign sgn_a    = is_div ? ~Funct3[0] : (Funct3[1:0] == 2'b01 || Funct3[1:0] == 2'b10);
    assign sgn_b    = is_div ? ~Funct3[0] : (Funct3[1:0] == 2'b01);
    assign sa       = sgn_a & SrcA[WIDTH-1];
    assign sb       = sgn_b & SrcB[WIDTH-1];
    assign mag_a    = sa ? -SrcA : SrcA;
    assign mag_b    = sb ? -SrcB : SrcB;
    assign div_zero = is_div && (SrcB == '0);
    assign div_ovf  = is_div && !Funct3[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    assign spec_val = div_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);

    // hi/lo hold {partial product, multiplier} for MUL* and {remainder, quotient} for DIV*
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    assign div_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, mb_q};
    assign prod     = {hi_q, lo_q};
    assign prod_fix = negq_q ? -prod : prod;
    assign quo_fix  = negq_q ? -lo_q : lo_q;
    assign rem_fix  = negr_q ? -hi_q : hi_q;

    always_comb begin
        final_res = '0;
        if (spec_q)               final_res = lo_q;
        else if (op_q[2])         final_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == '0) final_res = prod_fix[WIDTH-1:0];
        else                      final_res = prod_fix[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mb_d    = mb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        spec_d  = spec_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d   = Funct3;
                    cnt_d  = '0;
                    hi_d   = '0;
                    negq_d = sa ^ sb;
                    negr_d = sa;
                    spec_d = div_zero | div_ovf;
                    mb_d   = is_div ? mag_b : mag_a;
                    lo_d   = (div_zero | div_ovf) ? spec_val : (is_div ? mag_a : mag_b);
                    state_d = (div_zero | div_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        hi_d = div_ge ? WIDTH'(div_sh - {1'b0, mb_q}) : div_sh[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    res_d  = final_res;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            mb_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            spec_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mb_q    <= mb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            spec_q  <= spec_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign Result = res_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and seeded-random bench for mdu_sequencer with an expected-result queue.
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        busy, done;
    logic [31:0] Result;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb_q[$];

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results from 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Launch one op, push its expectation, then wait (bounded) for done and compare.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  n;
        bit  got;
        logic [31:0] e;
        Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = f ^ 3'b101;
        n = 0; got = 0;
        while (!got && n < 100) begin
            start = (n == 3);
            @(posedge clk); #1;
            n++;
            if (n == 1 && lat > 1) check({tag, " busy"}, {31'b0, busy}, 32'd1);
            if (done) got = 1;
        end
        start = 1'b0;
        check({tag, " latency"}, n, lat);
        e = sb_q.pop_front();
        if (got) begin
            check({tag, " busy@done"}, {31'b0, busy}, 32'd0);
            check({tag, " result"}, Result, e);
        end
    endtask

    task automatic watch_no_done(input string tag, input int cycles, input logic [31:0] held);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check({tag, " no done"}, seen, 0);
        check({tag, " result held"}, Result, held);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb, keep;
        int          rl;
        reset = 1'b1; start = 1'b0; flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
        #23;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", Result, 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        run_op("MUL 7*-3", 3'd0, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        @(posedge clk); #1;
        check("done one-cycle", {31'b0, done}, 32'd0);

        // Async reset in the middle of a computation
        Funct3 = 3'd3; SrcA = 32'h7; SrcB = 32'hFFFFFFFD; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #3; reset = 1'b1; #1;
        check("mid reset busy", {31'b0, busy}, 32'd0);
        check("mid reset done", {31'b0, done}, 32'd0);
        check("mid reset result", Result, 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        run_op("MULHU 7*-3", 3'd3, 32'h7, 32'hFFFFFFFD, 32'h00000006, 33);
        run_op("MULH min*min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("MULHSU -1*max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("MULH -7*3", 3'd1, 32'hFFFFFFF9, 32'h3, 32'hFFFFFFFF, 33);
        run_op("DIV -7/2", 3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
        run_op("REM -7/2", 3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_op("DIVU min/-1", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33);
        run_op("REMU min/-1", 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        run_op("DIV x/0", 3'd4, 32'h1234, 32'h0, 32'hFFFFFFFF, 1);
        run_op("REMU 5/0", 3'd7, 32'd5, 32'h0, 32'd5, 1);
        run_op("DIV ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
        run_op("DIVU 5/0", 3'd5, 32'd5, 32'h0, 32'hFFFFFFFF, 1);
        run_op("REM 7/0", 3'd6, 32'd7, 32'h0, 32'd7, 1);

        // Flush at counter=10
        keep = 32'd7;
        Funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush calc busy", {31'b0, busy}, 32'd0);
        watch_no_done("flush calc", 40, keep);

        // Flush while in DONE (special-case op)
        Funct3 = 3'd4; SrcA = 32'd9; SrcB = 32'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush done busy", {31'b0, busy}, 32'd0);
        watch_no_done("flush done", 5, keep);

        // Flush beats start in IDLE
        Funct3 = 3'd4; SrcA = 32'd9; SrcB = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("flush idle busy", {31'b0, busy}, 32'd0);
        watch_no_done("flush idle", 5, keep);

        // Back-to-back: start accepted in the cycle done is high
        run_op("b2b MUL", 3'd0, 32'h12345678, 32'h9ABCDEF0, model(3'd0, 32'h12345678, 32'h9ABCDEF0), 33);
        run_op("b2b DIV", 3'd4, 32'h9ABCDEF0, 32'h00001234, model(3'd4, 32'h9ABCDEF0, 32'h00001234), 33);

        for (int i = 0; i < 8; i++) begin
            rf = 3'(i);
            ra = $urandom;
            rb = (i == 5) ? ($urandom & 32'hFF) + 32'd1 : $urandom;
            rl = 33;
            run_op("rand", rf, ra, rb, model(rf, ra, rb), rl);
        end

        check("scoreboard empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
